dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/loader).
- Each requester uses a req/ack handshake. The block owns the memory's address, write-data, write-enable and read-enable lines, and guarantees the write and read enables are never high together.
- Round-robin arbitration with bounded locking allows short bursts without starving the other port.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/rr_pick2.sv | 14 +
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester port indices.
// Combinational only; no latency or backpressure of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time goes.
// Zero latency; pure combinational, no backpressure.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;
  assign pick  = (req0 & req1) ? ~lastGrant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CPU (port 0) and debug (port 1) via req/ack.
// Ack 2 cycles after req is sampled in IDLE (locked bursts: 1 access / 2 cycles); a port waits on req until acked.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  state_t            state;
  logic              owner;
  logic              lastGrant;
  logic [LOCK_W-1:0] lockCnt;

  logic pickValid;
  logic pick;

  rr_pick2 uPick (
    .req0      (req0),
    .req1      (req1),
    .lastGrant (lastGrant),
    .valid     (pickValid),
    .pick      (pick)
  );

  logic                  ownWe;
  logic                  ownLock;
  logic                  ownReq;
  logic                  otherReq;
  logic [DATA_WIDTH-1:0] ownAddr;
  logic [DATA_WIDTH-1:0] ownWdata;

  assign ownWe    = (owner == P_DBG) ? we1    : we0;
  assign ownLock  = (owner == P_DBG) ? lock1  : lock0;
  assign ownReq   = (owner == P_DBG) ? req1   : req0;
  assign otherReq = (owner == P_DBG) ? req0   : req1;
  assign ownAddr  = (owner == P_DBG) ? addr1  : addr0;
  assign ownWdata = (owner == P_DBG) ? wdata1 : wdata0;

  // rst gates the enables directly so a reset landing mid-ACCESS can never commit a write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state == ST_ACCESS) begin
      mem_addr  = ownAddr;
      mem_wdata = ownWdata;
      mem_we    = ownWe & ~rst;
      mem_re    = ~ownWe & ~rst;
    end
  end

  assign ack0 = (state == ST_RESP) && (owner == P_CPU);
  assign ack1 = (state == ST_RESP) && (owner == P_DBG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= P_CPU;
      lastGrant <= P_DBG;
      lockCnt   <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pickValid) begin
            owner <= pick;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!ownWe) begin
            if (owner == P_DBG) rdata1 <= mem_rdata;
            else                rdata0 <= mem_rdata;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          lastGrant <= owner;
          // The lock budget is only spent while the other port is actually waiting.
          if (ownLock && ownReq && (lockCnt < LOCK_LAST)) begin
            state <= ST_ACCESS;
            if (otherReq) lockCnt <= lockCnt + 1'b1;
          end else begin
            lockCnt <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: memory model, ack scoreboard with expected cycle and read data.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_we, mem_re;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] memArr [0:65535];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] rdata;
    int          cyc;
  } sbEnt_t;

  sbEnt_t sbQ[$];
  sbEnt_t ent;

  dmem_arbiter #(.DATA_WIDTH(16), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_we) memArr[mem_addr] <= mem_wdata;
  assign mem_rdata = memArr[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic p, input logic w, input logic [15:0] d, input int c);
    sbEnt_t e;
    e.port = p; e.we = w; e.rdata = d; e.cyc = c;
    sbQ.push_back(e);
  endtask

  // Every cycle: enable/ack exclusivity, and each ack popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mutexWeRe", 32'(mem_we & mem_re), 32'd0);
      chk("mutexAck", 32'(ack0 & ack1), 32'd0);
      if (ack0 | ack1) begin
        if (sbQ.size() == 0) begin
          chk("spuriousAck", 32'({ack0, ack1}), 32'd0);
        end else begin
          ent = sbQ.pop_front();
          chk("ackPort", 32'(ack1), 32'(ent.port));
          chk("ackCycle", 32'(cyc), 32'(ent.cyc));
          if (!ent.we) chk("ackRdata", 32'(ent.port ? rdata1 : rdata0), 32'(ent.rdata));
        end
      end
    end
  end

  task automatic doAccess(input logic p, input logic w, input logic lk,
                          input logic [15:0] a, input logic [15:0] d);
    logic got;
    got = 1'b0;
    if (p) begin req1 = 1'b1; we1 = w; lock1 = lk; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; lock0 = lk; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = p ? ack1 : ack0;
    end
    if (!got) chk("ackTimeout", 32'(got), 32'd1);
  endtask

  task automatic runPort(input logic p, input logic w, input logic lk, input logic [15:0] a,
                         input logic [15:0] d, input int n, input logic incAddr);
    for (int i = 0; i < n; i++)
      doAccess(p, w, lk, incAddr ? a + 16'(i) : a, d + 16'(i));
    if (p) begin req1 = 1'b0; lock1 = 1'b0; end
    else   begin req0 = 1'b0; lock0 = 1'b0; end
  endtask

  int c;

  initial begin
    repeat (3) @(negedge clk);
    chk("rstAck", 32'({ack0, ack1}), 32'd0);
    chk("rstRdata0", 32'(rdata0), 32'd0);
    chk("rstRdata1", 32'(rdata1), 32'd0);
    chk("rstMemEn", 32'({mem_we, mem_re}), 32'd0);
    #1 rst = 1'b0;

    // Single write, checked cycle by cycle.
    @(negedge clk);
    c = cyc;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd3; wdata0 = 16'hBEEF;
    push(1'b0, 1'b1, 16'h0, c + 2);
    #1 chk("idleWe", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("accWe", 32'({mem_we, mem_re}), 32'b10);
    chk("accAddr", 32'(mem_addr), 32'd3);
    chk("accWdata", 32'(mem_wdata), 32'hBEEF);
    chk("accNoAck", 32'(ack0), 32'd0);
    @(negedge clk);
    chk("respWe", 32'(mem_we), 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);

    // Read back the same word.
    c = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
    push(1'b0, 1'b0, 16'hBEEF, c + 2);
    @(negedge clk);
    chk("rdAccEn", 32'({mem_we, mem_re}), 32'b01);
    @(negedge clk);
    chk("rdData", 32'(rdata0), 32'hBEEF);
    req0 = 1'b0;
    @(negedge clk);

    // Seed word 5 for the reset test.
    c = cyc;
    push(1'b0, 1'b1, 16'h0, c + 2);
    runPort(1'b0, 1'b1, 1'b0, 16'd5, 16'h5555, 1, 1'b0);
    @(negedge clk);

    // Both ports held, no lock: strict alternation, port 1 first since port 0 went last.
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b1, 16'h0, c + 2 + 6 * i);
      push(1'b0, 1'b0, 16'hBEEF, c + 5 + 6 * i);
    end
    fork
      runPort(1'b0, 1'b0, 1'b0, 16'd3, 16'h0, 3, 1'b0);
      runPort(1'b1, 1'b1, 1'b0, 16'd20, 16'hC000, 3, 1'b1);
    join
    chk("altMem21", 32'(memArr[21]), 32'hC001);
    @(negedge clk);

    // Port 0 locked with port 1 waiting: four bursts, then port 1, then port 0's fifth.
    c = cyc;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 16'h0, c + 2 + 2 * i);
    push(1'b1, 1'b0, 16'hBEEF, c + 11);
    push(1'b0, 1'b1, 16'h0, c + 14);
    fork
      runPort(1'b0, 1'b1, 1'b1, 16'd40, 16'hA000, 5, 1'b1);
      begin
        @(negedge clk);
        runPort(1'b1, 1'b0, 1'b0, 16'd3, 16'h0, 1, 1'b0);
      end
    join
    chk("lockMem44", 32'(memArr[44]), 32'hA004);
    @(negedge clk);

    // Reset during the ACCESS cycle of a port-1 write must not commit it.
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd5; wdata1 = 16'h1234;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rstAccWe", 32'({mem_we, mem_re}), 32'd0);
    @(negedge clk);
    chk("rstNoAck", 32'({ack0, ack1}), 32'd0);
    chk("rstIdleAddr", 32'(mem_addr), 32'd0);
    chk("rstMem5", 32'(memArr[5]), 32'h5555);
    #1 rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    c = cyc;
    push(1'b1, 1'b0, 16'h5555, c + 2);
    runPort(1'b1, 1'b0, 1'b0, 16'd5, 16'h0, 1, 1'b0);
    repeat (3) @(negedge clk);

    chk("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
